// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - IF stage: owns the PC, issues in-order imem fetches, buffers words for decode
//
// Parameters:
//   XLEN        address/datapath width
//   RESET_PC    PC loaded by reset
//   FIFO_DEPTH  fetch buffer entries (power of 2, >= 2)
//
// Ports:
//   clk, reset                     clock, synchronous active-high reset
//   imem_req/imem_addr             fetch request and its address (always pc_f)
//   imem_gnt                       request accepted this cycle
//   imem_rvalid/imem_rdata         in-order read return, >= 1 cycle after gnt
//   id_valid/id_instr/id_pc        head of fetch buffer to decode (nop/0 when empty)
//   id_ready                       decode accepts the head entry
//   redirect/redirect_pc           control-flow redirect from decode, flushes younger work
//   perf_fetched/perf_redirects    event counters, only with FETCH_PERF_EN defined
//
// Build option: FETCH_PERF_EN adds the two performance counters and their ports.

module fetch_unit #(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    output logic            id_valid,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc,
    input  logic            id_ready,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_redirects
`endif
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Outstanding-request tracker
    localparam logic [1:0] ST_IDLE = 2'b00;  // nothing outstanding
    localparam logic [1:0] ST_WAIT = 2'b01;  // one request outstanding, data wanted
    localparam logic [1:0] ST_DROP = 2'b10;  // one request outstanding, data squashed

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [XLEN-1:0] pc_f;
    logic [XLEN-1:0] req_pc;

    logic [XLEN-1:0] fifo_pc    [FIFO_DEPTH];
    logic [31:0]     fifo_instr [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic busy;
    logic credit;
    logic fifo_empty;
    logic fifo_full;
    logic fire;
    logic push;
    logic pop;

    // The low two bits of a redirect target are dropped by alignment.
    logic unused_redirect_lsbs;
    assign unused_redirect_lsbs = ^redirect_pc[1:0];

    assign busy       = (state == ST_WAIT) || (state == ST_DROP);
    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));

    // An outstanding request already owns a buffer slot, so it is counted
    // against the depth. A pop in the same cycle is deliberately not credited,
    // which keeps imem_req independent of id_ready.
    assign credit = (count + CNT_W'(busy)) < CNT_W'(FIFO_DEPTH);

    // Issue from IDLE, or back-to-back from WAIT when the previous word is
    // returning this cycle. Held low while reset is applied.
    assign imem_req = !reset && !redirect && credit &&
                      ((state == ST_IDLE) || ((state == ST_WAIT) && imem_rvalid));
    assign imem_addr = pc_f;

    assign fire = imem_req && imem_gnt;
    assign push = !redirect && (state == ST_WAIT) && imem_rvalid;
    assign pop  = !fifo_empty && id_ready && !redirect;

    always_comb begin
        state_nxt = state;
        if (redirect) begin
            // A returning word is discarded; a still-pending one becomes DROP.
            if (busy) begin
                state_nxt = imem_rvalid ? ST_IDLE : ST_DROP;
            end else begin
                state_nxt = ST_IDLE;
            end
        end else if (fire) begin
            state_nxt = ST_WAIT;
        end else if (busy && imem_rvalid) begin
            state_nxt = ST_IDLE;
        end else if (!busy) begin
            // Also scrubs the unused encoding back to IDLE.
            state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            pc_f   <= RESET_PC;
            req_pc <= RESET_PC;
        end else begin
            state <= state_nxt;
            if (redirect) begin
                pc_f <= {redirect_pc[XLEN-1:2], 2'b00};
            end else if (fire) begin
                req_pc <= pc_f;
                pc_f   <= pc_f + XLEN'(4);
            end
        end
    end

    // Buffer storage carries no reset; validity lives in count.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_pc[wr_ptr]    <= req_pc;
            fifo_instr[wr_ptr] <= imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || redirect) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // The credit scheme must never let a word arrive with no room for it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && fifo_full && !pop));
        end
    end

    assign id_valid = !fifo_empty;
    assign id_instr = fifo_empty ? NOP_INSTR : fifo_instr[rd_ptr];
    assign id_pc    = fifo_empty ? '0        : fifo_pc[rd_ptr];

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched   <= '0;
            perf_redirects <= '0;
        end else begin
            if (pop) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (redirect) begin
                perf_redirects <= perf_redirects + 32'd1;
            end
        end
    end
`else
    // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized self-checking bench for fetch_unit with a behavioural model

module tb_fetch_unit;

    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] RST_PC2 = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset       = 1'b1;
    logic        imem_gnt    = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = 32'h0;
    logic        id_ready    = 1'b1;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = 32'h0;

    logic        imem_req,  imem_req2;
    logic [31:0] imem_addr, imem_addr2;
    logic        id_valid,  id_valid2;
    logic [31:0] id_instr,  id_instr2;
    logic [31:0] id_pc,     id_pc2;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched,  perf_fetched2;
    logic [31:0] perf_redirects, perf_redirects2;
`endif

    fetch_unit #(.XLEN(32), .RESET_PC(RST_PC), .FIFO_DEPTH(2)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc), .id_ready(id_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_redirects(perf_redirects)
`endif
    );

    // Same stimulus, wrapping reset PC: tracks dut with a fixed PC offset until the first redirect.
    fetch_unit #(.XLEN(32), .RESET_PC(RST_PC2), .FIFO_DEPTH(2)) dut2 (
        .clk(clk), .reset(reset),
        .imem_req(imem_req2), .imem_addr(imem_addr2), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_valid(id_valid2), .id_instr(id_instr2), .id_pc(id_pc2), .id_ready(id_ready),
        .redirect(redirect), .redirect_pc(redirect_pc)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched2), .perf_redirects(perf_redirects2)
`endif
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
    endfunction

    // Memory: one request at a time, in order, latency lat_min..lat_max cycles.
    int          gnt_mode = 1;       // 0 never, 1 always, 2 random
    int          lat_min  = 1;
    int          lat_max  = 1;
    logic        mem_pending = 1'b0;
    logic        mem_stale   = 1'b0; // request issued before a reset
    logic [31:0] mem_addr    = 32'h0;
    int          mem_wait    = 0;

    always @(posedge clk) begin
        #2;
        imem_rvalid = mem_pending && (mem_wait == 0);
        imem_rdata  = imem_rvalid ? word_of(mem_addr) : $urandom;
        imem_gnt    = !reset && (!mem_pending || imem_rvalid) &&
                      ((gnt_mode == 1) || ((gnt_mode == 2) && ($urandom_range(0, 3) != 0)));
    end

    // Model state
    logic [31:0] exp_fetch = RST_PC;
    logic [31:0] exp_dec   = RST_PC;
    logic [31:0] off2      = 32'hFFFF_FFFC;
    logic [31:0] m_fetched = 0;
    logic [31:0] m_redir   = 0;
    logic        prev_reset = 1'b0;
    logic        prev_flush = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_pc, prev_instr;
    int          pops = 0;

    // Compare process: every cycle, then advance model and memory.
    always @(negedge clk) begin
        if (reset) begin
            if (prev_reset) begin
                chk("rst_req", imem_req, 0);
                chk("rst_valid", id_valid, 0);
            end
            exp_fetch  = RST_PC;
            exp_dec    = RST_PC;
            off2       = 32'hFFFF_FFFC;
            m_fetched  = 0;
            m_redir    = 0;
            prev_stall = 1'b0;
        end else begin
            if (!id_valid) begin
                chk("gate_instr", id_instr, 32'h0000_0013);
                chk("gate_pc", id_pc, 0);
            end
            if (prev_flush) chk("flush_valid", id_valid, 0);
            if (prev_stall) begin
                chk("stall_valid", id_valid, 1);
                chk("stall_pc", id_pc, prev_pc);
                chk("stall_instr", id_instr, prev_instr);
            end
            chk("fetch_pc", imem_addr, exp_fetch);
            if (redirect) chk("req_on_redirect", imem_req, 0);
            if (mem_pending && !mem_stale && !imem_rvalid) chk("one_outstanding", imem_req, 0);
            chk("d2_req", imem_req2, imem_req);
            chk("d2_valid", id_valid2, id_valid);
            chk("d2_addr", imem_addr2, imem_addr + off2);
            if (id_valid) begin
                chk("d2_pc", id_pc2, id_pc + off2);
                chk("d2_instr", id_instr2, id_instr);
            end
`ifdef FETCH_PERF_EN
            chk("perf_fetched", perf_fetched, m_fetched);
            chk("perf_redirects", perf_redirects, m_redir);
            chk("d2_perf", perf_fetched2, m_fetched);
`endif
            if (id_valid && id_ready && !redirect) begin
                chk("pop_pc", id_pc, exp_dec);
                chk("pop_instr", id_instr, word_of(exp_dec));
                exp_dec   = exp_dec + 32'd4;
                m_fetched = m_fetched + 1;
                pops++;
            end
            if (imem_req && imem_gnt) exp_fetch = exp_fetch + 32'd4;
            if (redirect) begin
                exp_fetch = redirect_pc & ~32'd3;
                exp_dec   = redirect_pc & ~32'd3;
                off2      = 32'h0;
                m_redir   = m_redir + 1;
            end
            prev_stall = id_valid && !id_ready && !redirect;
            prev_pc    = id_pc;
            prev_instr = id_instr;
        end
        prev_flush = reset || redirect;
        prev_reset = reset;

        if (imem_rvalid) begin
            mem_pending = 1'b0;
            mem_stale   = 1'b0;
        end else if (mem_pending) begin
            mem_wait = mem_wait - 1;
        end
        if (reset && mem_pending) mem_stale = 1'b1;
        if (!reset && imem_req && imem_gnt) begin
            mem_pending = 1'b1;
            mem_stale   = 1'b0;
            mem_addr    = imem_addr;
            mem_wait    = $urandom_range(lat_min, lat_max) - 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        redirect = 1'b0;
        tick();
        tick();
        for (int i = 0; i < 8 && mem_pending; i++) tick();
        reset = 1'b0;
    endtask

    int rst_hold = 0;

    initial begin
        // 1: single-cycle memory, credit-limited stream; 5: wrapping reset PC on dut2
        gnt_mode = 1; lat_min = 1; lat_max = 1; id_ready = 1'b1;
        do_reset();
        at_neg();
        chk("t1_req", imem_req, 1);
        chk("t1_addr", imem_addr, 32'h0);
        chk("t1_valid0", id_valid, 0);
        tick(); tick();
        at_neg();
        chk("t1_pc0", id_pc, 32'h0);
        chk("t1_instr0", id_instr, 32'h00C0_FFEE);
        chk("t5_pc0", id_pc2, 32'hFFFF_FFFC);
        tick(); at_neg();
        chk("t1_pc1", id_pc, 32'h4);
        chk("t5_pc1", id_pc2, 32'h0);
        tick(); at_neg();
        chk("t1_bubble", id_valid, 0);
        tick(); at_neg();
        chk("t1_pc2", id_pc, 32'h8);
        tick(); at_neg();
        chk("t1_pc3", id_pc, 32'hC);
        tick();

        // 2: decode stalled six cycles
        id_ready = 1'b0;
        do_reset();
        tick(); tick(); tick();
        for (int i = 0; i < 3; i++) begin
            at_neg();
            chk("t2_req", imem_req, 0);
            chk("t2_valid", id_valid, 1);
            chk("t2_pc", id_pc, 32'h0);
            tick();
        end
        id_ready = 1'b1;
        at_neg();
        chk("t2_rel_pc0", id_pc, 32'h0);
        tick(); at_neg();
        chk("t2_rel_pc1", id_pc, 32'h4);
        repeat (6) tick();

        // 4: redirect with a returning word and a valid head entry
        do_reset();
        tick(); tick();
        redirect = 1'b1; redirect_pc = 32'h203;
        at_neg();
        chk("t4_head", id_pc, 32'h0);
        tick();
        redirect = 1'b0;
        at_neg();
        chk("t4_valid", id_valid, 0);
        chk("t4_req", imem_req, 1);
        chk("t4_addr", imem_addr, 32'h200);
`ifdef FETCH_PERF_EN
        chk("t4_perf_redir", perf_redirects, 1);
        chk("t4_perf_fetch", perf_fetched, 0);
`endif
        tick(); tick(); at_neg();
        chk("t4_pc", id_pc, 32'h200);
        tick();

        // 3: latency 3, redirect while WAIT
        lat_min = 3; lat_max = 3;
        do_reset();
        tick();
        redirect = 1'b1; redirect_pc = 32'h100;
        at_neg();
        chk("t3_req_redir", imem_req, 0);
        tick();
        redirect = 1'b0;
        at_neg();
        chk("t3_drop_req", imem_req, 0);
        tick(); at_neg();
        chk("t3_drop_rvalid_req", imem_req, 0);
        chk("t3_drop_valid", id_valid, 0);
        tick(); at_neg();
        chk("t3_req", imem_req, 1);
        chk("t3_addr", imem_addr, 32'h100);
        repeat (4) tick();
        at_neg();
        chk("t3_valid", id_valid, 1);
        chk("t3_pc", id_pc, 32'h100);
        tick();

        // 6: reset mid-WAIT, word returns after reset
        do_reset();
        tick();
        reset = 1'b1;
        tick();
        at_neg();
        chk("t6_req", imem_req, 0);
        chk("t6_valid", id_valid, 0);
        tick();
        reset = 1'b0;
        at_neg();
        chk("t6_valid_late", id_valid, 0);
        chk("t6_addr", imem_addr, RST_PC);
        tick(); at_neg();
        chk("t6_valid_after", id_valid, 0);
`ifdef FETCH_PERF_EN
        chk("t6_perf_fetch", perf_fetched, 0);
        chk("t6_perf_redir", perf_redirects, 0);
`endif

        // Randomized traffic
        gnt_mode = 2; lat_min = 1; lat_max = 4;
        for (int c = 0; c < 4000; c++) begin
            tick();
            if (rst_hold > 0) begin
                reset = 1'b1;
                rst_hold--;
            end else if ($urandom_range(0, 299) == 0) begin
                reset = 1'b1;
                rst_hold = 1;
            end else begin
                reset = 1'b0;
            end
            redirect    = ($urandom_range(0, 15) == 0);
            redirect_pc = $urandom;
            id_ready    = ($urandom_range(0, 3) != 0);
        end
        tick();
        reset = 1'b0; redirect = 1'b0; id_ready = 1'b1;
        repeat (8) tick();
        chk("progress", (pops > 200) ? 32'd1 : 32'd0, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
